// File: rtl/restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock; results P_WIDTH cycles after start, 1 cycle for divide-by-zero.
// No backpressure: i_START is only sampled while idle, outputs hold until the next accepted start.
module restoring_divider #(
    parameter int P_WIDTH = 8
) (
    input  logic               i_CLK,
    input  logic               i_RST,
    input  logic               i_START,
    input  logic [P_WIDTH-1:0] i_DIVIDEND,
    input  logic [P_WIDTH-1:0] i_DIVISOR,
    output logic               o_BUSY,
    output logic               o_DONE,
    output logic [P_WIDTH-1:0] o_QUOTIENT,
    output logic [P_WIDTH-1:0] o_REMAINDER,
    output logic               o_DIV_BY_ZERO
);

    localparam int CW = $clog2(P_WIDTH + 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [P_WIDTH-1:0] d;
    logic [P_WIDTH-1:0] q;
    // Restored remainder is always below D, so its top bit is always zero and is not stored.
    logic [P_WIDTH-1:0] r;

    logic [P_WIDTH:0]   shifted;
    logic [P_WIDTH:0]   trial;
    logic               q_bit;
    logic [P_WIDTH-1:0] r_next;
    logic [P_WIDTH-1:0] q_next;

    always_comb begin
        shifted = {r, q[P_WIDTH-1]};
        trial   = shifted - {1'b0, d};
        q_bit   = ~trial[P_WIDTH];
        r_next  = q_bit ? trial[P_WIDTH-1:0] : shifted[P_WIDTH-1:0];
        q_next  = {q[P_WIDTH-2:0], q_bit};
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state         <= IDLE;
            cnt           <= '0;
            d             <= '0;
            q             <= '0;
            r             <= '0;
            o_BUSY        <= 1'b0;
            o_DONE        <= 1'b0;
            o_QUOTIENT    <= '0;
            o_REMAINDER   <= '0;
            o_DIV_BY_ZERO <= 1'b0;
        end else begin
            o_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_START) begin
                        if (i_DIVISOR != '0) begin
                            d             <= i_DIVISOR;
                            q             <= i_DIVIDEND;
                            r             <= '0;
                            cnt           <= CW'(P_WIDTH);
                            o_DIV_BY_ZERO <= 1'b0;
                            o_BUSY        <= 1'b1;
                            state         <= CALC;
                        end else begin
                            o_QUOTIENT    <= '1;
                            o_REMAINDER   <= i_DIVIDEND;
                            o_DIV_BY_ZERO <= 1'b1;
                            o_DONE        <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q_next;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        o_QUOTIENT  <= q_next;
                        o_REMAINDER <= r_next;
                        o_DONE      <= 1'b1;
                        o_BUSY      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider against plain integer division.
module tb_restoring_divider;

    localparam int W = 8;

    logic         i_CLK;
    logic         i_RST;
    logic         i_START;
    logic [W-1:0] i_DIVIDEND;
    logic [W-1:0] i_DIVISOR;
    logic         o_BUSY;
    logic         o_DONE;
    logic [W-1:0] o_QUOTIENT;
    logic [W-1:0] o_REMAINDER;
    logic         o_DIV_BY_ZERO;

    int errors = 0;
    int checks = 0;

    restoring_divider #(.P_WIDTH(W)) dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_START       (i_START),
        .i_DIVIDEND    (i_DIVIDEND),
        .i_DIVISOR     (i_DIVISOR),
        .o_BUSY        (o_BUSY),
        .o_DONE        (o_DONE),
        .o_QUOTIENT    (o_QUOTIENT),
        .o_REMAINDER   (o_REMAINDER),
        .o_DIV_BY_ZERO (o_DIV_BY_ZERO)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_CLK);
        #1;
    endtask

    // Reference: ordinary integer division; divide-by-zero yields all ones and the dividend.
    function automatic logic [31:0] ref_q(input int a, input int b);
        return (b == 0) ? 32'(2**W - 1) : 32'(a / b);
    endfunction

    function automatic logic [31:0] ref_r(input int a, input int b);
        return (b == 0) ? 32'(a) : 32'(a % b);
    endfunction

    task automatic start_op(input int a, input int b);
        i_DIVIDEND = W'(a);
        i_DIVISOR  = W'(b);
        i_START    = 1'b1;
        tick();
        i_START    = 1'b0;
    endtask

    // Counts cycles from the accepting edge until o_DONE, bounded.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = 0;
        while (!o_DONE && lat < 40) begin
            if (o_BUSY) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input int a, input int b);
        int lat, bc;
        start_op(a, b);
        wait_done(lat, bc);
        chk({tag, " latency"}, 32'(lat), (b == 0) ? 32'd0 : 32'(W));
        chk({tag, " busy_cycles"}, 32'(bc), (b == 0) ? 32'd0 : 32'(W));
        chk({tag, " quotient"}, 32'(o_QUOTIENT), ref_q(a, b));
        chk({tag, " remainder"}, 32'(o_REMAINDER), ref_r(a, b));
        chk({tag, " div_by_zero"}, 32'(o_DIV_BY_ZERO), (b == 0) ? 32'd1 : 32'd0);
        tick();
        chk({tag, " done_one_cycle"}, 32'(o_DONE), 32'd0);
    endtask

    initial begin
        int lat, bc, pulses, total, a, b;

        i_RST = 1'b1;
        i_START = 1'b0;
        i_DIVIDEND = '0;
        i_DIVISOR = '0;
        #12;
        i_RST = 1'b0;
        tick();
        chk("reset busy", 32'(o_BUSY), 32'd0);
        chk("reset done", 32'(o_DONE), 32'd0);
        chk("reset quotient", 32'(o_QUOTIENT), 32'd0);
        chk("reset remainder", 32'(o_REMAINDER), 32'd0);
        chk("reset dbz", 32'(o_DIV_BY_ZERO), 32'd0);

        run_div("100/7", 100, 7);
        run_div("255/1", 255, 1);
        run_div("5/9", 5, 9);
        run_div("0/3", 0, 3);
        run_div("255/255", 255, 255);
        run_div("77/0", 77, 0);
        run_div("13/5 after dbz", 13, 5);

        // Start during CALC must be ignored.
        start_op(200, 3);
        tick();
        tick();
        i_DIVIDEND = 8'd9;
        i_DIVISOR  = 8'd4;
        i_START    = 1'b1;
        tick();
        i_START = 1'b0;
        lat = 3;
        pulses = 0;
        bc = 0;
        while (lat < 16) begin
            if (o_DONE) begin
                pulses++;
                bc = lat;
                chk("ignore quotient", 32'(o_QUOTIENT), 32'd66);
                chk("ignore remainder", 32'(o_REMAINDER), 32'd2);
            end
            tick();
            lat++;
        end
        chk("ignore done_pulses", 32'(pulses), 32'd1);
        chk("ignore latency", 32'(bc), 32'd8);

        // Asynchronous reset in the middle of a division.
        start_op(200, 3);
        tick();
        tick();
        tick();
        chk("pre-reset busy", 32'(o_BUSY), 32'd1);
        #2;
        i_RST = 1'b1;
        #1;
        chk("async reset busy", 32'(o_BUSY), 32'd0);
        chk("async reset done", 32'(o_DONE), 32'd0);
        chk("async reset quotient", 32'(o_QUOTIENT), 32'd0);
        chk("async reset remainder", 32'(o_REMAINDER), 32'd0);
        chk("async reset dbz", 32'(o_DIV_BY_ZERO), 32'd0);
        tick();
        i_RST = 1'b0;
        tick();
        chk("post-reset idle", 32'(o_BUSY), 32'd0);
        run_div("10/3 after reset", 10, 3);

        // Back-to-back random divisions, next start issued in each done cycle.
        total = 0;
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(1, 255));
        start_op(a, b);
        for (int i = 0; i < 1000; i++) begin
            wait_done(lat, bc);
            total += lat;
            chk("rand latency", 32'(lat), 32'(W));
            chk("rand quotient", 32'(o_QUOTIENT), ref_q(a, b));
            chk("rand remainder", 32'(o_REMAINDER), ref_r(a, b));
            if (i < 999) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(1, 255));
                start_op(a, b);
            end
        end
        chk("rand throughput cycles", 32'(total), 32'(1000 * W));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
